muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the RV32 M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 tb/tb_muldiv_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with an optional single-cycle path for the RISC-V special cases.
module muldiv_seq #(
  parameter int XLEN           = 32,
  parameter bit SPECIAL_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg;
  logic [CW-1:0]       count_reg;
  logic [2:0]          f3_reg;
  logic [XLEN-1:0]     opnd_reg;      // multiplicand (MUL*) or divisor (DIV*) magnitude
  logic [2*XLEN-1:0]   p_reg;         // {hi, lo}: product, or {remainder, quotient}
  logic                neg_lo_reg;
  logic                neg_rem_reg;
  logic                spec_reg;
  logic [XLEN-1:0]     spec_val_reg;
  logic [XLEN-1:0]     result_reg;
  logic                busy_reg;
  logic                done_reg;

  logic                is_div, sa, sb, neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, ovf, spec_hit;
  logic [XLEN-1:0]     spec_val;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;
  logic [2*XLEN-1:0]   p_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;
  logic [XLEN-1:0]     result_next;

  // Operand decode: only sampled on IDLE & start.
  always_comb begin
    is_div   = funct3[2];
    sa       = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
    sb       = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    neg_a    = sa & op_a[XLEN-1];
    neg_b    = sb & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div_zero = is_div & (op_b == '0);
    ovf      = is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    spec_hit = div_zero | ovf;
    if (div_zero) spec_val = funct3[1] ? op_a : '1;
    else          spec_val = funct3[1] ? '0 : op_a;
  end

  // One iteration of either datapath.
  always_comb begin
    mul_sum   = {1'b0, p_reg[2*XLEN-1:XLEN]} + (p_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {p_reg[2*XLEN-1:XLEN], p_reg[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
    if (f3_reg[2]) begin
      if (div_diff[XLEN+1])
        p_next = {div_shift[XLEN-1:0], p_reg[XLEN-2:0], 1'b0};
      else
        p_next = {div_diff[XLEN-1:0], p_reg[XLEN-2:0], 1'b1};
    end else begin
      p_next = {mul_sum, p_reg[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select, taken from the final iteration's output.
  always_comb begin
    prod = neg_lo_reg  ? -p_next : p_next;
    quo  = neg_lo_reg  ? -p_next[XLEN-1:0] : p_next[XLEN-1:0];
    rem  = neg_rem_reg ? -p_next[2*XLEN-1:XLEN] : p_next[2*XLEN-1:XLEN];
    if (f3_reg[2])
      result_next = f3_reg[1] ? rem : quo;
    else
      result_next = (f3_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (spec_reg)
      result_next = spec_val_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      f3_reg       <= '0;
      opnd_reg     <= '0;
      p_reg        <= '0;
      neg_lo_reg   <= 1'b0;
      neg_rem_reg  <= 1'b0;
      spec_reg     <= 1'b0;
      spec_val_reg <= '0;
      result_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            f3_reg       <= funct3;
            opnd_reg     <= is_div ? mag_b : mag_a;
            p_reg        <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            neg_lo_reg   <= neg_a ^ neg_b;
            neg_rem_reg  <= neg_a;
            spec_reg     <= spec_hit;
            spec_val_reg <= spec_val;
            count_reg    <= '0;
            if (SPECIAL_BYPASS && spec_hit) begin
              result_reg <= spec_val;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end else begin
              busy_reg   <= 1'b1;
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          p_reg     <= p_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(XLEN-1)) begin
            result_reg <= result_next;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign stall  = ~rst & (((state_reg == IDLE) & start) | (state_reg == CALC));
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, stall window, reset abort, back-to-back ops.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  muldiv_seq #(.XLEN(32), .SPECIAL_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done, check result / done cycle / stall-high cycle count.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat = -1;
    int stall_cnt = 0;
    @(posedge clk); #1;
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    #1;
    if (stall) stall_cnt++;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (stall) stall_cnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    @(posedge clk); #1;
    check({tag, " done_drop"}, {63'd0, done}, 64'd0);
    check({tag, " result_hold"}, 64'(result), 64'(exp_res));
    $display("op %s f3=%0d a=%h b=%h -> result=%h done_cycle=%0d", tag, f3, a, b, result, lat);
  endtask

  initial begin
    int done_cnt;
    int done_at [2];
    int stall_lo;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst result", 64'(result), 64'd0);
    start = 1'b1; #1;
    check("rst stall_forced", {63'd0, stall}, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("MUL 7*-3",       3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH min*-1",    3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("MULHSU min*-1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("MULHU",          3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33);
    run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("DIV 7/-2",       3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("REM 7/-2",       3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("DIVU x/0",       3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1);
    run_op("REM 5/0",        3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("MUL 6*7",        3'b000, 32'd6,        32'd7,        32'd42,       33);

    // Reset in the middle of a DIV.
    @(posedge clk); #1;
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("abort busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1; #1;
    check("abort stall_in_rst", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort result", 64'(result), 64'd0);
    rst = 1'b0; start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort no_done", 64'(done_cnt), 64'd0);
    $display("reset abort: busy=%b result=%h done_pulses=%0d", busy, result, done_cnt);

    // Two back-to-back MULs with start held high throughout.
    @(posedge clk); #1;
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    done_cnt = 0; stall_lo = 0; done_at[0] = -1; done_at[1] = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (!stall) stall_lo++;
      if (done) begin
        if (done_cnt < 2) done_at[done_cnt] = cyc;
        if (done_cnt == 0) begin
          check("b2b first_result", 64'(result), 64'd42);
          op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
        end else begin
          check("b2b second_result", 64'(result), 64'd1);
        end
        done_cnt++;
        if (done_cnt == 2) break;
      end
    end
    start = 1'b0;
    check("b2b done_count", 64'(done_cnt), 64'd2);
    check("b2b first_at", 64'(done_at[0]), 64'd33);
    check("b2b spacing", 64'(done_at[1] - done_at[0]), 64'd34);
    check("b2b stall_releases", 64'(stall_lo), 64'd2);
    $display("back-to-back: done at %0d and %0d, stall low %0d cycles", done_at[0], done_at[1], stall_lo);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
